bus_err_tracker: RTL and testbench
==================================

# bus_err_tracker

ID-aware, multi-channel bus error unit. Records the address and metadata of every outstanding request per channel and transaction ID. When a response carries a non-zero error code, it logs the error with its channel, address and metadata into an error FIFO, raises an interrupt and keeps a running error count. It sits beside a manager port (or a bundle of ports) and replaces the in-order, one-hot-channel error unit where responses can return out of order by ID and channels handshake concurrently.

## Interface
- AddrWidth, 48, request address width
- MetaDataWidth, 1, request metadata width (≥1)
- ErrBits, 3, response error code width; code 0 means OK
- IdWidth, 2, transaction ID width; each channel has 2**IdWidth table entries
- NumChannels, 2, independent channels (≥1); concurrent handshakes allowed
- NumStoredErrors, 4, error FIFO depth (≥2)
- DropOldest, 0, 1: a full FIFO evicts its head to accept a new error; 0: new errors wait
- CntWidth, 16, error counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumChannels  request handshake completed, per channel
- req_id_i  in  NumChannels×IdWidth  request ID
- req_addr_i  in  NumChannels×AddrWidth  request address
- req_meta_i  in  NumChannels×MetaDataWidth  request metadata
- rsp_valid_i  in  NumChannels  response beat handshake completed
- rsp_last_i  in  NumChannels  beat is the last of its burst
- rsp_id_i  in  NumChannels×IdWidth  response ID
- rsp_err_i  in  NumChannels×ErrBits  response error code
- err_irq_o  out  1  error FIFO not empty
- err_pop_i  in  1  pop FIFO head
- err_code_o  out  ErrBits  head error code
- err_chan_o  out  max(1,$clog2(NumChannels))  head channel index
- err_addr_o  out  AddrWidth  head address; 0 when err_addr_valid_o=0
- err_meta_o  out  MetaDataWidth  head metadata; 0 when err_addr_valid_o=0
- err_addr_valid_o  out  1  head address/meta trustworthy
- err_overflow_o  out  1  sticky: at least one error discarded
- overflow_clr_i  in  1  clears err_overflow_o
- err_cnt_o  out  CntWidth  saturating count of detected errors

## Operation
- Table entry per (channel, ID): {busy, poisoned, logged, addr, meta}.
- Request: writes addr/meta and sets busy, clears logged. If busy is already set, also sets poisoned (ID reused before completion).
- Response beat: looks up entry[rsp_id]. An error is *detected* on the beat if rsp_err≠0 and logged=0. Detection sets logged, so each burst logs at most once. A beat on a non-busy entry is treated as poisoned.
- Last beat clears busy, poisoned and logged.
- Request and last-beat on the same channel and ID in the same cycle: the response uses the old contents; the request's write determines the final state (busy=1, poisoned=0).
- Detection loads a per-channel pending slot {code, addr, meta, addr_valid = ~poisoned}. If the slot is still occupied, the new error is discarded and err_overflow_o is set.
- A round-robin arbiter (pointer advances past the granted channel) moves one pending slot per cycle into the FIFO.
- FIFO full with DropOldest=0: no grant; slots hold.
- FIFO full with DropOldest=1: the head is popped and the new error is pushed in the same cycle; err_overflow_o is set.
- err_pop_i on an empty FIFO is ignored. A user pop and a DropOldest eviction in the same cycle count as one pop.
- err_cnt_o increments on every detection, including discarded ones, and saturates at all-ones. Multiple detections in one cycle add their number, saturating.
- overflow_clr_i clears the flag; a set in the same cycle wins.

## Timing
- Reset: all outputs 0, table and pending slots empty, arbiter pointer 0.
- A request in cycle t is visible to responses from t+1.
- Error detected in cycle t: slot loaded at t+1; FIFO push at the end of t+1 if granted and not full; err_irq_o and head outputs valid at t+2. err_cnt_o updates at t+1.
- FIFO is not fall-through. After a pop in cycle t, the next head appears at t+1.
- Reset asserted mid-operation clears everything asynchronously. Responses to IDs issued before reset are then handled as poisoned.

## Test plan
- Channel 0: request ID 1 at address 0x1000, then a 4-beat response with err=2 on beats 2 and 3 -> one FIFO entry {code 2, chan 0, addr 0x1000, valid 1}; err_cnt_o=1; err_irq_o rises 2 cycles after beat 2.
- Requests ID0 @0xA0 and ID1 @0xB0; responses ID1 err=1, then ID0 err=3 -> FIFO order 0xB0/1 then 0xA0/3 (out-of-order lookup).
- Both channels detect errors in the same cycle, repeated 3 times with FIFO depth ≥6 -> entries alternate ch0, ch1 (round-robin); err_cnt_o=6.
- ID reused while busy, then an error response -> err_addr_valid_o=0, err_addr_o=0; a response on an idle ID behaves the same.
- DropOldest=0, depth 2: 4 errors on one channel with no pops -> 2 entries kept, 1 held in the pending slot, 1 discarded; err_overflow_o=1, err_cnt_o=4. DropOldest=1: the FIFO holds the newest two.
- Request and last-beat with err=5 on the same ID in the same cycle -> the error uses the old address; the entry stays busy with the new address; a later error response reports the new address.

Source files
------------

// File: rtl/bus_err_tracker.sv
// bus_err_tracker: ID-aware, multi-channel bus error logger.
// A per-(channel, ID) table remembers the address/metadata of every
// outstanding request. Erroring responses land in a per-channel pending
// slot, and a round-robin arbiter moves the slots into a small error FIFO.
module bus_err_tracker #(
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned MetaDataWidth   = 1,
  parameter int unsigned ErrBits         = 3,
  parameter int unsigned IdWidth         = 2,
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned NumStoredErrors = 4,
  parameter bit          DropOldest      = 1'b0,
  parameter int unsigned CntWidth        = 16,
  localparam int unsigned ChanW          = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumChannels-1:0]                 req_valid_i,
  input  logic [NumChannels*IdWidth-1:0]         req_id_i,
  input  logic [NumChannels*AddrWidth-1:0]       req_addr_i,
  input  logic [NumChannels*MetaDataWidth-1:0]   req_meta_i,
  input  logic [NumChannels-1:0]                 rsp_valid_i,
  input  logic [NumChannels-1:0]                 rsp_last_i,
  input  logic [NumChannels*IdWidth-1:0]         rsp_id_i,
  input  logic [NumChannels*ErrBits-1:0]         rsp_err_i,
  output logic                                   err_irq_o,
  input  logic                                   err_pop_i,
  output logic [ErrBits-1:0]                     err_code_o,
  output logic [ChanW-1:0]                       err_chan_o,
  output logic [AddrWidth-1:0]                   err_addr_o,
  output logic [MetaDataWidth-1:0]               err_meta_o,
  output logic                                   err_addr_valid_o,
  output logic                                   err_overflow_o,
  input  logic                                   overflow_clr_i,
  output logic [CntWidth-1:0]                    err_cnt_o
);

  localparam int unsigned NumIds = 1 << IdWidth;
  localparam int unsigned PtrW   = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
  localparam int unsigned FillW  = $clog2(NumStoredErrors + 1);
  localparam int unsigned DetW   = $clog2(NumChannels + 1);
  localparam int unsigned SumW   = CntWidth + 1;

  // Circular FIFO pointer increment with wrap at the FIFO depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == PtrW'(NumStoredErrors - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  // Outstanding-request table.
  logic [NumIds-1:0]        busy_q   [NumChannels];
  logic [NumIds-1:0]        poison_q [NumChannels];
  logic [NumIds-1:0]        logged_q [NumChannels];
  logic [AddrWidth-1:0]     tbl_addr_q [NumChannels][NumIds];
  logic [MetaDataWidth-1:0] tbl_meta_q [NumChannels][NumIds];

  // Response lookup results.
  logic [IdWidth-1:0]       rsp_id_s   [NumChannels];
  logic [ErrBits-1:0]       rsp_err_s  [NumChannels];
  logic [NumChannels-1:0]   detect_s;
  logic [NumChannels-1:0]   hit_av_s;
  logic [AddrWidth-1:0]     hit_addr_s [NumChannels];
  logic [MetaDataWidth-1:0] hit_meta_s [NumChannels];

  // Pending slots.
  logic [NumChannels-1:0]   pend_valid_q;
  logic [NumChannels-1:0]   pend_av_q;
  logic [ErrBits-1:0]       pend_code_q [NumChannels];
  logic [AddrWidth-1:0]     pend_addr_q [NumChannels];
  logic [MetaDataWidth-1:0] pend_meta_q [NumChannels];

  // Arbiter.
  logic [ChanW-1:0]         rr_ptr_q;
  logic                     grant_en_s;
  logic                     grant_valid_s;
  logic [ChanW-1:0]         grant_idx_s;
  logic [NumChannels-1:0]   granted_s;

  // Error FIFO.
  logic [ErrBits-1:0]         fifo_code_q [NumStoredErrors];
  logic [ChanW-1:0]           fifo_chan_q [NumStoredErrors];
  logic [AddrWidth-1:0]       fifo_addr_q [NumStoredErrors];
  logic [MetaDataWidth-1:0]   fifo_meta_q [NumStoredErrors];
  logic [NumStoredErrors-1:0] fifo_av_q;
  logic [PtrW-1:0]            wr_ptr_q;
  logic [PtrW-1:0]            rd_ptr_q;
  logic [FillW-1:0]           fill_q;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic                       push_s;
  logic                       evict_s;
  logic                       pop_s;

  // Counter and overflow flag.
  logic [DetW-1:0]          det_num_s;
  logic [SumW-1:0]          cnt_sum_s;
  logic [CntWidth-1:0]      err_cnt_d;
  logic [CntWidth-1:0]      err_cnt_q;
  logic                     ovf_set_s;
  logic                     ovf_q;

  assign fifo_full_s  = (fill_q == FillW'(NumStoredErrors));
  assign fifo_empty_s = (fill_q == '0);
  assign push_s       = grant_valid_s;
  assign evict_s      = grant_valid_s && fifo_full_s;
  assign pop_s        = (err_pop_i && !fifo_empty_s) || evict_s;

  // Look up each response in its channel's table; an idle or reused ID yields untrusted address.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      rsp_id_s[c]  = rsp_id_i[c*IdWidth +: IdWidth];
      rsp_err_s[c] = rsp_err_i[c*ErrBits +: ErrBits];
      detect_s[c]  = rsp_valid_i[c] && (rsp_err_s[c] != '0) && !logged_q[c][rsp_id_s[c]];
      hit_av_s[c]  = busy_q[c][rsp_id_s[c]] && !poison_q[c][rsp_id_s[c]];
      if (hit_av_s[c]) begin
        hit_addr_s[c] = tbl_addr_q[c][rsp_id_s[c]];
        hit_meta_s[c] = tbl_meta_q[c][rsp_id_s[c]];
      end else begin
        hit_addr_s[c] = '0;
        hit_meta_s[c] = '0;
      end
    end
  end

  // Table update: a request's write overrides a same-cycle response on that entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        busy_q[c]   <= '0;
        poison_q[c] <= '0;
        logged_q[c] <= '0;
        for (int i = 0; i < NumIds; i++) begin
          tbl_addr_q[c][i] <= '0;
          tbl_meta_q[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        for (int i = 0; i < NumIds; i++) begin
          if (req_valid_i[c] && (req_id_i[c*IdWidth +: IdWidth] == IdWidth'(i))) begin
            tbl_addr_q[c][i] <= req_addr_i[c*AddrWidth +: AddrWidth];
            tbl_meta_q[c][i] <= req_meta_i[c*MetaDataWidth +: MetaDataWidth];
            busy_q[c][i]     <= 1'b1;
            logged_q[c][i]   <= 1'b0;
            // Reuse only poisons if the old burst is not finishing this very cycle.
            poison_q[c][i]   <= busy_q[c][i] &&
                                !(rsp_valid_i[c] && rsp_last_i[c] && (rsp_id_s[c] == IdWidth'(i)));
          end else if (rsp_valid_i[c] && (rsp_id_s[c] == IdWidth'(i))) begin
            if (rsp_last_i[c]) begin
              busy_q[c][i]   <= 1'b0;
              poison_q[c][i] <= 1'b0;
              logged_q[c][i] <= 1'b0;
            end else if (detect_s[c]) begin
              logged_q[c][i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Round-robin arbiter: search from the pointer; blocked when the FIFO is full and may not evict.
  always_comb begin
    grant_en_s    = !fifo_full_s || DropOldest;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    granted_s     = '0;
    for (int k = 0; k < NumChannels; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % int'(NumChannels);
      if (grant_en_s && !grant_valid_s && pend_valid_q[idx]) begin
        grant_valid_s  = 1'b1;
        grant_idx_s    = ChanW'(idx);
        granted_s[idx] = 1'b1;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Arbiter pointer moves to the channel after the one granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (grant_valid_s) begin
      rr_ptr_q <= (grant_idx_s == ChanW'(NumChannels - 1)) ? '0 : grant_idx_s + ChanW'(1);
    end
  end

  // Pending slots: load on detection if free (or freed by this cycle's grant), else hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= '0;
      pend_av_q    <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        pend_code_q[c] <= '0;
        pend_addr_q[c] <= '0;
        pend_meta_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (detect_s[c] && (!pend_valid_q[c] || granted_s[c])) begin
          pend_valid_q[c] <= 1'b1;
          pend_av_q[c]    <= hit_av_s[c];
          pend_code_q[c]  <= rsp_err_s[c];
          pend_addr_q[c]  <= hit_addr_s[c];
          pend_meta_q[c]  <= hit_meta_s[c];
        end else if (granted_s[c]) begin
          pend_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // Error FIFO storage and pointers; an eviction and a user pop merge into one pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      fifo_av_q <= '0;
      for (int e = 0; e < NumStoredErrors; e++) begin
        fifo_code_q[e] <= '0;
        fifo_chan_q[e] <= '0;
        fifo_addr_q[e] <= '0;
        fifo_meta_q[e] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_code_q[wr_ptr_q] <= pend_code_q[grant_idx_s];
        fifo_chan_q[wr_ptr_q] <= grant_idx_s;
        fifo_addr_q[wr_ptr_q] <= pend_addr_q[grant_idx_s];
        fifo_meta_q[wr_ptr_q] <= pend_meta_q[grant_idx_s];
        fifo_av_q[wr_ptr_q]   <= pend_av_q[grant_idx_s];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   fill_q <= fill_q + FillW'(1);
        2'b01:   fill_q <= fill_q - FillW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Saturating sum of all detections this cycle, discarded ones included.
  always_comb begin
    det_num_s = '0;
    for (int c = 0; c < NumChannels; c++) begin
      det_num_s = det_num_s + DetW'(detect_s[c]);
    end
    cnt_sum_s = {1'b0, err_cnt_q} + SumW'(det_num_s);
    if (cnt_sum_s[CntWidth]) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = cnt_sum_s[CntWidth-1:0];
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ovf_set_s = (|(detect_s & pend_valid_q & ~granted_s)) || evict_s;

  // Sticky overflow flag; a set beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_q <= 1'b1;
    end else if (overflow_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign err_irq_o        = !fifo_empty_s;
  assign err_code_o       = fifo_empty_s ? '0   : fifo_code_q[rd_ptr_q];
  assign err_chan_o       = fifo_empty_s ? '0   : fifo_chan_q[rd_ptr_q];
  assign err_addr_o       = fifo_empty_s ? '0   : fifo_addr_q[rd_ptr_q];
  assign err_meta_o       = fifo_empty_s ? '0   : fifo_meta_q[rd_ptr_q];
  assign err_addr_valid_o = fifo_empty_s ? 1'b0 : fifo_av_q[rd_ptr_q];
  assign err_overflow_o   = ovf_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_bus_err_tracker.sv
// Directed bench for bus_err_tracker. Instance A: depth 8, no eviction.
// B: depth 2, new errors wait, 3-bit count. C: depth 2, drop-oldest, 2-bit count.
module tb_bus_err_tracker;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_id;
  logic [95:0] req_addr;
  logic [1:0]  req_meta;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_last;
  logic [3:0]  rsp_id;
  logic [5:0]  rsp_err;
  logic        pop_a, pop_b, pop_c, ovf_clr;

  logic        irq_a, irq_b, irq_c;
  logic [2:0]  code_a, code_b, code_c;
  logic [0:0]  chan_a, chan_b, chan_c;
  logic [47:0] addr_a, addr_b, addr_c;
  logic [0:0]  meta_a, meta_b, meta_c;
  logic        av_a, av_b, av_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic [1:0]  cnt_c;

  int n_chk  = 0;
  int n_pass = 0;

  bus_err_tracker #(.NumStoredErrors(8), .DropOldest(1'b0), .CntWidth(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_id_i(req_id),
    .req_addr_i(req_addr), .req_meta_i(req_meta), .rsp_valid_i(rsp_valid),
    .rsp_last_i(rsp_last), .rsp_id_i(rsp_id), .rsp_err_i(rsp_err),
    .err_irq_o(irq_a), .err_pop_i(pop_a), .err_code_o(code_a), .err_chan_o(chan_a),
    .err_addr_o(addr_a), .err_meta_o(meta_a), .err_addr_valid_o(av_a),
    .err_overflow_o(ovf_a), .overflow_clr_i(ovf_clr), .err_cnt_o(cnt_a));

  bus_err_tracker #(.NumStoredErrors(2), .DropOldest(1'b0), .CntWidth(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_id_i(req_id),
    .req_addr_i(req_addr), .req_meta_i(req_meta), .rsp_valid_i(rsp_valid),
    .rsp_last_i(rsp_last), .rsp_id_i(rsp_id), .rsp_err_i(rsp_err),
    .err_irq_o(irq_b), .err_pop_i(pop_b), .err_code_o(code_b), .err_chan_o(chan_b),
    .err_addr_o(addr_b), .err_meta_o(meta_b), .err_addr_valid_o(av_b),
    .err_overflow_o(ovf_b), .overflow_clr_i(ovf_clr), .err_cnt_o(cnt_b));

  bus_err_tracker #(.NumStoredErrors(2), .DropOldest(1'b1), .CntWidth(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_id_i(req_id),
    .req_addr_i(req_addr), .req_meta_i(req_meta), .rsp_valid_i(rsp_valid),
    .rsp_last_i(rsp_last), .rsp_id_i(rsp_id), .rsp_err_i(rsp_err),
    .err_irq_o(irq_c), .err_pop_i(pop_c), .err_code_o(code_c), .err_chan_o(chan_c),
    .err_addr_o(addr_c), .err_meta_o(meta_c), .err_addr_valid_o(av_c),
    .err_overflow_o(ovf_c), .overflow_clr_i(ovf_clr), .err_cnt_o(cnt_c));

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    req_valid = 2'b00; req_id = 4'h0; req_addr = 96'h0; req_meta = 2'b00;
    rsp_valid = 2'b00; rsp_last = 2'b00; rsp_id = 4'h0; rsp_err = 6'h0;
    pop_a = 1'b0; pop_b = 1'b0; pop_c = 1'b0; ovf_clr = 1'b0;
  endtask

  // Inputs set before step() are sampled at the next edge, then cleared.
  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic set_req(input int ch, input logic [1:0] id, input logic [47:0] a, input logic m);
    req_valid[ch]       = 1'b1;
    req_id[ch*2 +: 2]   = id;
    req_addr[ch*48 +: 48] = a;
    req_meta[ch]        = m;
  endtask

  task automatic set_rsp(input int ch, input logic [1:0] id, input logic last, input logic [2:0] err);
    rsp_valid[ch]      = 1'b1;
    rsp_last[ch]       = last;
    rsp_id[ch*2 +: 2]  = id;
    rsp_err[ch*3 +: 3] = err;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    @(posedge clk);
    #1;
    chk("rst_irq",  irq_a, 1'b0);
    chk("rst_cnt",  cnt_a, 16'd0);
    chk("rst_code", code_a, 3'd0);
    chk("rst_addr", addr_a, 48'h0);
    chk("rst_av",   av_a, 1'b0);
    chk("rst_ovf",  ovf_a, 1'b0);
    rst_n = 1'b1;
    step();
  endtask

  logic [47:0] t3_addr [7] = '{48'h103, 48'h200, 48'h100, 48'h201, 48'h101, 48'h202, 48'h102};
  logic [0:0]  t3_chan [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  t3_code [7] = '{3'd7, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1};
  logic [0:0]  t3_meta [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    idle_in();

    // Burst with errors on beats 2 and 3 logs once.
    do_reset();
    set_req(0, 2'd1, 48'h1000, 1'b1); step();
    set_rsp(0, 2'd1, 1'b0, 3'd0); step();
    chk("t1_cnt0", cnt_a, 16'd0);
    set_rsp(0, 2'd1, 1'b0, 3'd2); step();
    chk("t1_cnt1", cnt_a, 16'd1);
    chk("t1_irq_early", irq_a, 1'b0);
    set_rsp(0, 2'd1, 1'b0, 3'd2); step();
    chk("t1_irq", irq_a, 1'b1);
    chk("t1_code", code_a, 3'd2);
    chk("t1_chan", chan_a, 1'b0);
    chk("t1_addr", addr_a, 48'h1000);
    chk("t1_meta", meta_a, 1'b1);
    chk("t1_av", av_a, 1'b1);
    set_rsp(0, 2'd1, 1'b1, 3'd0); step();
    step();
    chk("t1_cnt_once", cnt_a, 16'd1);
    pop_a = 1'b1; step();
    chk("t1_irq_pop", irq_a, 1'b0);
    pop_a = 1'b1; step();
    chk("t1_pop_empty", irq_a, 1'b0);
    set_req(0, 2'd2, 48'h2222, 1'b0); step();
    set_rsp(0, 2'd2, 1'b1, 3'd7); step(); step();
    chk("t1_irq2", irq_a, 1'b1);
    chk("t1_code2", code_a, 3'd7);
    chk("t1_addr2", addr_a, 48'h2222);
    chk("t1_cnt2", cnt_a, 16'd2);

    // Out-of-order responses by ID.
    do_reset();
    set_req(0, 2'd0, 48'hA0, 1'b0); step();
    set_req(0, 2'd1, 48'hB0, 1'b0); step();
    set_rsp(0, 2'd1, 1'b1, 3'd1); step();
    set_rsp(0, 2'd0, 1'b1, 3'd3); step();
    step(); step();
    chk("t2_code_a", code_a, 3'd1);
    chk("t2_addr_a", addr_a, 48'hB0);
    pop_a = 1'b1; step();
    chk("t2_code_b", code_a, 3'd3);
    chk("t2_addr_b", addr_a, 48'hA0);
    pop_a = 1'b1; step();
    chk("t2_irq", irq_a, 1'b0);
    chk("t2_cnt", cnt_a, 16'd2);

    // Round-robin between channels.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(0, 2'(k), 48'h100 + 48'(k), 1'b0);
      set_req(1, 2'(k), 48'h200 + 48'(k), 1'b1);
      step();
    end
    set_req(0, 2'd3, 48'h103, 1'b1); step();
    set_rsp(0, 2'd3, 1'b1, 3'd7); step(); step(); step();
    for (int k = 0; k < 3; k++) begin
      set_rsp(0, 2'(k), 1'b1, 3'd1);
      set_rsp(1, 2'(k), 1'b1, 3'd4);
      step(); step(); step();
    end
    step();
    chk("t3_cnt", cnt_a, 16'd7);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t3_chan%0d", k), chan_a, t3_chan[k]);
      chk($sformatf("t3_addr%0d", k), addr_a, t3_addr[k]);
      chk($sformatf("t3_code%0d", k), code_a, t3_code[k]);
      chk($sformatf("t3_meta%0d", k), meta_a, t3_meta[k]);
      pop_a = 1'b1; step();
    end
    chk("t3_irq", irq_a, 1'b0);

    // Reused and idle IDs give untrusted addresses.
    do_reset();
    set_req(1, 2'd2, 48'h300, 1'b0); step();
    set_req(1, 2'd2, 48'h310, 1'b1); step();
    set_rsp(1, 2'd2, 1'b1, 3'd6); step(); step(); step();
    chk("t4_av", av_a, 1'b0);
    chk("t4_addr", addr_a, 48'h0);
    chk("t4_meta", meta_a, 1'b0);
    chk("t4_code", code_a, 3'd6);
    chk("t4_chan", chan_a, 1'b1);
    pop_a = 1'b1; step();
    set_rsp(1, 2'd3, 1'b1, 3'd2); step(); step(); step();
    chk("t4_idle_av", av_a, 1'b0);
    chk("t4_idle_addr", addr_a, 48'h0);
    chk("t4_idle_code", code_a, 3'd2);
    pop_a = 1'b1; step();
    set_req(1, 2'd2, 48'h320, 1'b1); step();
    set_rsp(1, 2'd2, 1'b1, 3'd1); step(); step(); step();
    chk("t4_clean_av", av_a, 1'b1);
    chk("t4_clean_addr", addr_a, 48'h320);
    chk("t4_cnt", cnt_a, 16'd3);

    // Request and last beat on the same ID in the same cycle.
    do_reset();
    set_req(0, 2'd1, 48'h400, 1'b0); step();
    set_req(0, 2'd1, 48'h500, 1'b1);
    set_rsp(0, 2'd1, 1'b1, 3'd5); step(); step(); step();
    chk("t5_code", code_a, 3'd5);
    chk("t5_old_addr", addr_a, 48'h400);
    chk("t5_old_av", av_a, 1'b1);
    pop_a = 1'b1; step();
    set_rsp(0, 2'd1, 1'b1, 3'd3); step(); step(); step();
    chk("t5_new_addr", addr_a, 48'h500);
    chk("t5_new_av", av_a, 1'b1);
    chk("t5_new_meta", meta_a, 1'b1);

    // Overflow behaviour on the depth-2 instances.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 2'(k), 48'h10 + 48'(k), 1'b0); step();
    end
    for (int k = 0; k < 4; k++) begin
      set_rsp(0, 2'(k), 1'b1, 3'(k + 1)); step(); step(); step();
    end
    step();
    chk("t6_a_ovf", ovf_a, 1'b0);
    chk("t6_a_cnt", cnt_a, 16'd4);
    chk("t6_b_ovf", ovf_b, 1'b1);
    chk("t6_b_cnt", cnt_b, 3'd4);
    chk("t6_b_head", code_b, 3'd1);
    chk("t6_b_addr", addr_b, 48'h10);
    chk("t6_c_ovf", ovf_c, 1'b1);
    chk("t6_c_cnt_sat", cnt_c, 2'd3);
    chk("t6_c_head", code_c, 3'd3);
    chk("t6_c_addr", addr_c, 48'h12);
    pop_b = 1'b1; pop_c = 1'b1; step();
    chk("t6_b_head2", code_b, 3'd2);
    chk("t6_c_head2", code_c, 3'd4);
    step();
    pop_b = 1'b1; pop_c = 1'b1; step();
    chk("t6_b_held", code_b, 3'd3);
    chk("t6_c_empty", irq_c, 1'b0);
    pop_b = 1'b1; step();
    chk("t6_b_empty", irq_b, 1'b0);
    ovf_clr = 1'b1; step();
    chk("t6_b_clr", ovf_b, 1'b0);
    chk("t6_c_clr", ovf_c, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
